// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared opcode, field-position and width definitions for the 20-bit pipeline
package pipeline_pkg;

    localparam int DEF_DATA_W  = 20;
    localparam int DEF_REG_AW  = 4;
    localparam int DEF_CNT_W   = 16;
    localparam int DEF_INSTR_W = 20;

    localparam int OPC_HI = 19;
    localparam int OPC_LO = 16;
    localparam int RD_HI  = 15;
    localparam int RD_LO  = 12;

    typedef logic [OPC_HI-OPC_LO:0] opcode_t;

    localparam opcode_t OP_ADD = 4'h0;
    localparam opcode_t OP_SUB = 4'h1;
    localparam opcode_t OP_AND = 4'h2;
    localparam opcode_t OP_OR  = 4'h3;
    localparam opcode_t OP_SLT = 4'h4;
    localparam opcode_t OP_LI  = 4'h5;
    localparam opcode_t OP_LW  = 4'h6;
    localparam opcode_t OP_SW  = 4'h7;
    localparam opcode_t OP_BEQ = 4'h8;
    localparam opcode_t OP_J   = 4'h9;
    localparam opcode_t OP_NOP = 4'hF;

    // Only ALU-class ops and loads produce a register result; everything else,
    // including the reserved 0xA-0xE range, retires without writing.
    function automatic logic writes_reg(input opcode_t opcode);
        case (opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_LI, OP_LW: return 1'b1;
            default:                                            return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/writeback_regfile_if.sv
// rtl/writeback_regfile_if.sv - MEM/WB input, decode read-port and write-back bus bundle
interface writeback_regfile_if
    import pipeline_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int REG_AW  = DEF_REG_AW,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int INSTR_W = DEF_INSTR_W
);

    logic                wb_valid;
    logic [INSTR_W-1:0]  instruction;
    logic [DATA_W-1:0]   alu_result;
    logic [DATA_W-1:0]   mem_read_data;
    logic [REG_AW-1:0]   rd_addr_a;
    logic [REG_AW-1:0]   rd_addr_b;
    logic [DATA_W-1:0]   rd_data_a;
    logic [DATA_W-1:0]   rd_data_b;
    logic                wb_we;
    logic [REG_AW-1:0]   wb_dest;
    logic [DATA_W-1:0]   wb_data;
    logic [CNT_W-1:0]    retire_count;

    modport master (
        output wb_valid, instruction, alu_result, mem_read_data, rd_addr_a, rd_addr_b,
        input  rd_data_a, rd_data_b, wb_we, wb_dest, wb_data, retire_count
    );

    modport slave (
        input  wb_valid, instruction, alu_result, mem_read_data, rd_addr_a, rd_addr_b,
        output rd_data_a, rd_data_b, wb_we, wb_dest, wb_data, retire_count
    );

endinterface

// File: rtl/register_file.sv
// rtl/register_file.sv - 2R/1W register file, r0 hardwired to zero, same-cycle write-through bypass
module register_file
    import pipeline_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int REG_AW = DEF_REG_AW
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              we,
    input  logic [REG_AW-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [REG_AW-1:0] rd_addr_a,
    input  logic [REG_AW-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b
);

    localparam int NREG = 1 << REG_AW;

    logic [DATA_W-1:0] regs [NREG];
    logic              wr_live;

    // r0 is never written, so its storage stays at the reset value of zero.
    assign wr_live = we && (wr_addr != '0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_live) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Address 0 wins over the bypass so r0 reads zero even when wb_dest is 0.
    always_comb begin
        rd_data_a = regs[rd_addr_a];
        if (rd_addr_a == '0) begin
            rd_data_a = '0;
        end else if (wr_live && (rd_addr_a == wr_addr)) begin
            rd_data_a = wr_data;
        end
    end

    always_comb begin
        rd_data_b = regs[rd_addr_b];
        if (rd_addr_b == '0) begin
            rd_data_b = '0;
        end else if (wr_live && (rd_addr_b == wr_addr)) begin
            rd_data_b = wr_data;
        end
    end

endmodule

// File: rtl/writeback_regfile.sv
// rtl/writeback_regfile.sv - write-back stage: result select, destination decode, commit and retire count
module writeback_regfile
    import pipeline_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int REG_AW = DEF_REG_AW,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic                clock,
    input  logic                reset,
    writeback_regfile_if.slave  bus
);

    opcode_t           opcode;
    logic [REG_AW-1:0] rd;
    logic              wb_we;
    logic [DATA_W-1:0] wb_data;
    logic [CNT_W-1:0]  retire_count;
    logic              instr_unused;

    assign opcode       = bus.instruction[OPC_HI:OPC_LO];
    assign rd           = bus.instruction[RD_HI:RD_LO];
    assign instr_unused = ^bus.instruction[RD_LO-1:0];

    // wb_valid gates first so an X instruction in a bubble cannot reach the file.
    always_comb begin
        wb_data = bus.alu_result;
        if (opcode == OP_LW) begin
            wb_data = bus.mem_read_data;
        end
        wb_we = 1'b0;
        if (bus.wb_valid) begin
            wb_we = writes_reg(opcode) && (rd != '0);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            retire_count <= '0;
        end else if (bus.wb_valid) begin
            retire_count <= retire_count + 1'b1;
        end
    end

    register_file #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW)
    ) u_register_file (
        .clock     (clock),
        .reset     (reset),
        .we        (wb_we),
        .wr_addr   (rd),
        .wr_data   (wb_data),
        .rd_addr_a (bus.rd_addr_a),
        .rd_addr_b (bus.rd_addr_b),
        .rd_data_a (bus.rd_data_a),
        .rd_data_b (bus.rd_data_b)
    );

    assign bus.wb_we        = wb_we;
    assign bus.wb_dest      = rd;
    assign bus.wb_data      = wb_data;
    assign bus.retire_count = retire_count;

endmodule
